// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM encoding, data width.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Op codes with the top bit set are reserved and never reach the ALU.
  function automatic logic op_reserved(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals around the arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [2:0]        alu_select;
  logic [DATA_W-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready, alu_result,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    output alu_data1, alu_data2, alu_select
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready, alu_result,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    input  alu_data1, alu_data2, alu_select
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; ptr names the requester served last.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    case (valid)
      2'b01: begin
        grant    = 2'b01;
        grant_id = 1'b0;
      end
      2'b10: begin
        grant    = 2'b10;
        grant_id = 1'b1;
      end
      2'b11: begin
        // Tie goes to whoever was not served last.
        grant_id = ~ptr;
        grant    = ptr ? 2'b01 : 2'b10;
      end
      default: begin
        grant    = 2'b00;
        grant_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters, one job in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WAIT_ADD   = 2,
  parameter int unsigned WAIT_OTHER = 1
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  state_t            state_reg;
  state_t            state_next;
  logic [3:0]        count_reg;
  logic [3:0]        load_count;
  logic              ptr_reg;
  logic [2:0]        sel_reg;
  logic [DATA_W-1:0] d1_reg;
  logic [DATA_W-1:0] d2_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_valid_reg;
  logic              rsp_id_reg;
  logic              rsp_err_reg;
  logic              job_err_reg;

  logic [1:0]        valid_vec;
  logic [1:0]        grant;
  logic [1:0]        ready_vec;
  logic              grant_id;
  logic              accept;
  logic              finish;
  logic [2:0]        acc_op;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;

  assign valid_vec = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_arb (
    .valid    (valid_vec),
    .ptr      (ptr_reg),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign acc_op = grant_id ? bus.req1_op : bus.req0_op;
  assign acc_a  = grant_id ? bus.req1_a  : bus.req0_a;
  assign acc_b  = grant_id ? bus.req1_b  : bus.req0_b;

  // Reserved ops take a one-cycle pass through EXEC so they answer after t+1.
  always_comb begin
    load_count = 4'(WAIT_OTHER);
    case (acc_op)
      OP_ADD:                load_count = 4'(WAIT_ADD);
      OP_FWD, OP_AND, OP_OR: load_count = 4'(WAIT_OTHER);
      default:               load_count = 4'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready_vec  = 2'b00;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready_vec = grant;
        if (grant != 2'b00) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (count_reg == 4'd1) begin
          finish     = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= 4'd0;
      ptr_reg       <= 1'b1;
      sel_reg       <= 3'b000;
      d1_reg        <= '0;
      d2_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      job_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        rsp_id_reg  <= grant_id;
        job_err_reg <= op_reserved(acc_op);
        count_reg   <= load_count;
        // The ALU keeps its previous operands when a reserved op is accepted.
        if (!op_reserved(acc_op)) begin
          sel_reg <= acc_op;
          d1_reg  <= acc_a;
          d2_reg  <= acc_b;
        end
      end else if (state_reg == ST_EXEC) begin
        count_reg <= count_reg - 4'd1;
      end

      if (finish) begin
        rsp_valid_reg <= 1'b1;
        rsp_data_reg  <= job_err_reg ? '0 : bus.alu_result;
        rsp_err_reg   <= job_err_reg;
      end else if (state_reg == ST_RESP && bus.rsp_ready) begin
        rsp_valid_reg <= 1'b0;
        ptr_reg       <= rsp_id_reg;
      end
    end
  end

  assign bus.req0_ready = ready_vec[0];
  assign bus.req1_ready = ready_vec[1];
  assign bus.rsp_valid  = rsp_valid_reg;
  assign bus.rsp_id     = rsp_id_reg;
  assign bus.rsp_data   = rsp_data_reg;
  assign bus.rsp_err    = rsp_err_reg;
  assign bus.alu_data1  = d1_reg;
  assign bus.alu_data2  = d2_reg;
  assign bus.alu_select = sel_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WADD = 2;
  localparam int WOTH = 3;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       err;
    logic [7:0] lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter #(.WAIT_ADD(WADD), .WAIT_OTHER(WOTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural model of the external ALU.
  always_comb begin
    case (bus.alu_select)
      OP_FWD:  bus.alu_result = bus.alu_data2;
      OP_ADD:  bus.alu_result = bus.alu_data1 + bus.alu_data2;
      OP_AND:  bus.alu_result = bus.alu_data1 & bus.alu_data2;
      OP_OR:   bus.alu_result = bus.alu_data1 | bus.alu_data2;
      default: bus.alu_result = 8'hEE;
    endcase
  end

  rsp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] last_sel = 3'b000;
  logic [7:0] last_d1 = 8'h00;
  logic [7:0] last_d2 = 8'h00;

  function automatic string fmt(input rsp_t r);
    return $sformatf("id=%0d data=%h err=%0d lat=%0d", r.id, r.data, r.err, r.lat);
  endfunction

  task automatic set_req(input bit id, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 1'b0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic push_exp(input bit id, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b);
    rsp_t e;
    e.id  = id;
    e.err = op[2];
    e.lat = 8'(op[2] ? 1 : ((op == OP_ADD) ? WADD : WOTH));
    case (op)
      OP_FWD:  e.data = b;
      OP_ADD:  e.data = a + b;
      OP_AND:  e.data = a & b;
      OP_OR:   e.data = a | b;
      default: e.data = 8'h00;
    endcase
    if (!op[2]) begin
      last_sel = op; last_d1 = a; last_d2 = b;
    end
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic submit(input bit id, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok = 1'b0;
    set_req(id, 1'b1, op, a, b);
    for (int i = 0; i < 40 && !ok; i++) begin
      #1;
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        ok = 1'b1;
        push_exp(id, op, a, b);
      end
      @(negedge clk);
    end
    set_req(id, 1'b0, op, a, b);
  endtask

  task automatic get_rsp(input int start, output rsp_t got, output rsp_t want);
    int lat;
    lat = start;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = {bus.rsp_id, bus.rsp_data, bus.rsp_err, 8'(lat)};
    if (sb.size() > 0) want = sb.pop_front();
    else want = '1;
    $display("[%0t] txn %s", $time, fmt(got));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_sel = 3'b000; last_d1 = 8'h00; last_d2 = 8'h00;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, bus.alu_data1, bus.alu_data2,
         bus.alu_select, bus.req0_ready, bus.req1_ready} !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: rsp_valid=%b id=%b err=%b data=%h d1=%h d2=%h sel=%b rdy=%b%b, required all zero",
               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, bus.alu_data1, bus.alu_data2,
               bus.alu_select, bus.req1_ready, bus.req0_ready);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: rsp_valid=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_add();
    bit ok;
    rsp_t got, want;
    submit(1'b0, OP_ADD, 8'h05, 8'h03, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL add_accept: no ready within bound, required ready"); end
    get_rsp(0, got, want);
    checks++;
    if (got !== want || want.data !== 8'h08) begin
      failures++;
      $display("FAIL add_rsp: got %s required %s (data 08)", fmt(got), fmt(want));
    end
    @(negedge clk);
  endtask

  task automatic test_tie();
    rsp_t got, want;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(1'b0, 1'b1, OP_OR, 8'hF0, 8'h0F);
      set_req(1'b1, 1'b1, OP_AND, 8'hFF, 8'h3C);
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
        failures++;
        $display("FAIL tie_grant%0d: ready=%b required 01", r, {bus.req1_ready, bus.req0_ready});
      end
      push_exp(1'b0, OP_OR, 8'hF0, 8'h0F);
      @(negedge clk);
      set_req(1'b0, 1'b0, OP_OR, 8'hF0, 8'h0F);
      #1;
      checks++;
      if (bus.req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL tie_busy%0d: req1_ready=%b required 0", r, bus.req1_ready);
      end
      get_rsp(0, got, want);
      checks++;
      if (got !== want || want.data !== 8'hFF) begin
        failures++;
        $display("FAIL tie_first%0d: got %s required %s", r, fmt(got), fmt(want));
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.req1_ready !== 1'b1) begin
        failures++;
        $display("FAIL tie_second_grant%0d: req1_ready=%b required 1", r, bus.req1_ready);
      end
      push_exp(1'b1, OP_AND, 8'hFF, 8'h3C);
      @(negedge clk);
      set_req(1'b1, 1'b0, OP_AND, 8'hFF, 8'h3C);
      get_rsp(0, got, want);
      checks++;
      if (got !== want || want.data !== 8'h3C) begin
        failures++;
        $display("FAIL tie_second%0d: got %s required %s", r, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reserved();
    bit ok;
    rsp_t got, want;
    submit(1'b1, 3'b101, 8'h11, 8'h22, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reserved_accept: no ready within bound, required ready"); end
    get_rsp(0, got, want);
    checks++;
    if (got !== want || want.err !== 1'b1 || want.lat !== 8'd1) begin
      failures++;
      $display("FAIL reserved_rsp: got %s required %s", fmt(got), fmt(want));
    end
    checks++;
    if ({bus.alu_select, bus.alu_data1, bus.alu_data2} !== {last_sel, last_d1, last_d2}) begin
      failures++;
      $display("FAIL reserved_alu_hold: sel=%b d1=%h d2=%h required sel=%b d1=%h d2=%h",
               bus.alu_select, bus.alu_data1, bus.alu_data2, last_sel, last_d1, last_d2);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok;
    rsp_t got, want;
    bus.rsp_ready = 1'b0;
    submit(1'b0, OP_OR, 8'h12, 8'h34, ok);
    get_rsp(0, got, want);
    checks++;
    if (!ok || got !== want || want.data !== 8'h36) begin
      failures++;
      $display("FAIL stall_rsp: accepted=%0d got %s required %s", ok, fmt(got), fmt(want));
    end
    set_req(1'b0, 1'b1, OP_ADD, 8'h01, 8'h01);
    set_req(1'b1, 1'b1, OP_AND, 8'h0F, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req1_ready, bus.req0_ready} !==
          {1'b1, want.id, want.data, want.err, 2'b00}) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b id=%b data=%h err=%b rdy=%b%b required 1 %b %h %b 00",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, bus.req1_ready,
                 bus.req0_ready, want.id, want.data, want.err);
      end
    end
    set_req(1'b0, 1'b0, OP_ADD, 8'h01, 8'h01);
    set_req(1'b1, 1'b0, OP_AND, 8'h0F, 8'hFF);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: rsp_valid=%b required 0", bus.rsp_valid);
    end
  endtask

  task automatic test_reset_exec();
    bit ok;
    bit seen;
    submit(1'b0, OP_ADD, 8'h40, 8'h02, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, bus.alu_data1, bus.alu_data2,
                bus.alu_select, bus.req0_ready, bus.req1_ready} !== 32'h0) begin
      failures++;
      $display("FAIL reset_exec_outputs: accepted=%0d valid=%b d1=%h d2=%h sel=%b data=%h required zeros",
               ok, bus.rsp_valid, bus.alu_data1, bus.alu_data2, bus.alu_select, bus.rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    last_sel = 3'b000; last_d1 = 8'h00; last_d2 = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_exec_no_rsp: rsp_valid seen=1 required 0");
    end
  endtask

  task automatic test_forward();
    bit ok;
    rsp_t got, want;
    submit(1'b0, OP_FWD, 8'h5A, 8'hA5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fwd_accept: no ready within bound, required ready"); end
    for (int i = 0; i < WOTH; i++) begin
      checks++;
      if ({bus.alu_select, bus.alu_data1, bus.alu_data2, bus.rsp_valid} !==
          {OP_FWD, 8'h5A, 8'hA5, 1'b0}) begin
        failures++;
        $display("FAIL fwd_stable%0d: sel=%b d1=%h d2=%h valid=%b required 000 5a a5 0",
                 i, bus.alu_select, bus.alu_data1, bus.alu_data2, bus.rsp_valid);
      end
      @(negedge clk);
    end
    get_rsp(WOTH, got, want);
    checks++;
    if (got !== want || want.data !== 8'hA5) begin
      failures++;
      $display("FAIL fwd_rsp: got %s required %s", fmt(got), fmt(want));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_tie();
    test_reserved();
    test_stall();
    test_reset_exec();
    test_forward();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 WAIT_ADD, 2, cycles operands are held on the ALU before sampling RESULT for ADD (SELECT 3'b001); legal range 1..15.
REQ-002 WAIT_OTHER, 1, cycles operands are held for FORWARD/AND/OR (3'b000/3'b010/3'b011); legal range 1..15.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 REQ0_VALID, REQ1_VALID  input  1 each  requester n offers a job.
REQ-006 REQ0_OP, REQ1_OP  input  3 each  ALU op code of requester n.
REQ-007 REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  8 each  operands (A to DATA1, B to DATA2).
REQ-008 REQ0_READY, REQ1_READY  output  1 each  job accepted when VALID and READY are high on a rising edge.
REQ-009 RSP_VALID  output  1  result available.
REQ-010 RSP_ID  output  1  index of requester owning the result.
REQ-011 RSP_DATA  output  8  result value.
REQ-012 RSP_ERR  output  1  reserved op code was submitted.
REQ-013 RSP_READY  input  1  response consumed when RSP_VALID and RSP_READY are high on a rising edge.
REQ-014 ALU_DATA1, ALU_DATA2  output  8 each  operands driven to the shared ALU.
REQ-015 ALU_SELECT  output  3  op code driven to the shared ALU.
REQ-016 ALU_RESULT  input  8  ALU output.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; one job in flight at a time.
REQ-018 IDLE: READY is combinational, asserted only to the granted requester, and only while that requester's VALID is high.
REQ-019 Grant: single VALID wins; both VALID -> requester other than last-served (round-robin pointer).
REQ-020 Accept edge: latch OP/A/B into registers that drive ALU_SELECT/DATA1/DATA2; latch RSP_ID; load counter with WAIT_ADD (op 001) or WAIT_OTHER (000/010/011); go to EXEC.
REQ-021 Reserved op (1xx) on accept: ALU registers unchanged, RSP_DATA=8'h00, RSP_ERR=1, go directly to RESP.
REQ-022 EXEC: counter decrements each cycle; ALU outputs stable; on the edge where counter equals 1, capture ALU_RESULT into RSP_DATA, RSP_ERR=0, go to RESP.
REQ-023 Latency: a valid-op job accepted at edge t asserts RSP_VALID after edge t+N (N = applicable WAIT); reserved-op job after edge t+1.
REQ-024 RESP: RSP_VALID, RSP_ID, RSP_DATA and RSP_ERR held stable until the handshake; READY outputs low.
REQ-025 RESP handshake: go to IDLE, pointer := RSP_ID; next accept no earlier than the following edge (throughput of at most one job per N+2 cycles).
REQ-026 ALU_DATA1/DATA2/SELECT keep their last values in IDLE and RESP (no toggling without a new job).
REQ-027 VALID dropped before acceptance: no effect; VALID on a non-granted requester in any state is ignored until granted.
REQ-028 All datapath widths are 8 bits; no arithmetic is performed in this block; RSP_DATA is ALU_RESULT unmodified.

Reset
REQ-029 RESET high: state IDLE, counter 0, pointer = 1 (requester 0 wins first tie), ALU_DATA1/DATA2 = 8'h00, ALU_SELECT = 3'b000, RSP_VALID/RSP_ID/RSP_ERR = 0, RSP_DATA = 8'h00, READY outputs 0.
REQ-030 RESET asserted mid-EXEC or mid-RESP aborts the job; no response is issued for that job after reset release.

Structure
REQ-031 Shared package alu_pkg holds op-code constants (FWD, ADD, AND, OR), the FSM state encoding, and the 8-bit data width constant.
REQ-032 One sub-module, rr_arbiter2 (two-way round-robin grant from two VALIDs and a pointer), is instantiated once; the rest lives in alu_arbiter.

Verification
REQ-033 REQ0 ADD A=8'h05 B=8'h03, RSP_READY=1, ALU model attached -> RSP_VALID 2 cycles after accept, RSP_DATA=8'h08, RSP_ID=0, RSP_ERR=0.
REQ-034 REQ0 and REQ1 VALID together after reset (OR 8'hF0/8'h0F; AND 8'hFF/8'h3C) -> REQ0 served first (8'hFF), then REQ1 (8'h3C); a repeat tie serves REQ0 first again since REQ1 was last served.
REQ-035 REQ1 op 3'b101 -> RSP_VALID one cycle after accept, RSP_ERR=1, RSP_DATA=8'h00, ALU_SELECT unchanged.
REQ-036 RSP_READY held low 5 cycles after RSP_VALID -> response fields stable all 5 cycles, both READY outputs low, no new accept.
REQ-037 RESET pulsed during EXEC of an ADD -> all outputs at reset values immediately; no RSP_VALID after release.
REQ-038 FORWARD B=8'hA5 with WAIT_OTHER=3 -> ALU outputs stable for 3 cycles, RSP_DATA=8'hA5.
